systolic_drain: RTL and testbench

Output-side collector for the systolic array: takes results leaving the last PE row, where column lane j lags lane 0 by j cycles, and realigns each result row. Aligned rows are buffered in a small FIFO and delivered to the downstream reader over a valid/ready handshake. It is the drain-side counterpart of the input skew/shift chain that feeds the array.

---
 rtl/systolic_drain.sv | 102 ++++++++++
 tb/tb_systolic_drain.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// systolic_drain: realigns skewed result lanes leaving the last PE row and queues whole rows for a valid/ready reader
//   clk        clock, all logic on posedge
//   clr_n      synchronous active-low reset
//   in_valid   per-lane result valid, lane j lags lane 0 by j cycles
//   in_data    per-lane result data, lane j at [j*W +: W]
//   in_ready   upstream may start a new row only while high
//   out_valid  aligned row at FIFO head
//   out_ready  downstream accepts the head row
//   out_data   aligned row, zero while out_valid is low
//   overflow   sticky, an aligned row was dropped on a full FIFO
//   skew_err   sticky, a partial row reached the alignment point
module systolic_drain #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           overflow,
    output logic           skew_err
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]   al_v;
    logic [N*W-1:0] al_d;

    // lane j waits N-1-j cycles so every lane of a row lands together
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int S = N - 1 - j;
        if (S == 0) begin : g_direct
            assign al_v[j]         = in_valid[j];
            assign al_d[j*W +: W]  = in_data[j*W +: W];
        end else begin : g_dly
            logic [S-1:0] v_q;
            logic [W-1:0] d_q [S];
            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= in_valid[j];
                    for (int k = 1; k < S; k++) v_q[k] <= v_q[k-1];
                end
            end
            always_ff @(posedge clk) begin
                d_q[0] <= in_data[j*W +: W];
                for (int k = 1; k < S; k++) d_q[k] <= d_q[k-1];
            end
            assign al_v[j]        = v_q[S-1];
            assign al_d[j*W +: W] = d_q[S-1];
        end
    end

    logic [N*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           ovf_q, ovf_d, skew_q, skew_d;
    logic           all_v, pop, push;

    assign out_valid = cnt_q != '0;
    assign out_data  = out_valid ? mem_q[rptr_q] : '0;
    // headroom for the rows still travelling through the deskew stages
    assign in_ready  = cnt_q <= (AW+1)'(DEPTH - N);
    assign overflow  = ovf_q;
    assign skew_err  = skew_q;

    always_comb begin
        all_v  = &al_v;
        pop    = out_valid & out_ready;
        push   = all_v & ((cnt_q != (AW+1)'(DEPTH)) | pop);
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d  = ovf_q | (all_v & ~push);
        skew_d = skew_q | ((|al_v) & ~all_v);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            skew_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            skew_q <= skew_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_n && push) mem_q[wptr_q] <= al_d;
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: randomized row traffic checked against a row-level queue model of the drain
module tb_systolic_drain;
    localparam int N = 4, W = 16, DEPTH = 8, MAXC = 4096;

    logic           clk = 1'b0;
    logic           clr_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           in_ready, out_valid, out_ready, overflow, skew_err;
    logic [N*W-1:0] out_data;

    always #5 clk = ~clk;

    systolic_drain #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow), .skew_err(skew_err)
    );

    int checks = 0, failures = 0, cyc = 0;
    bit armed = 0;
    logic [N-1:0]   row_mask [MAXC];
    logic [W-1:0]   row_dat  [MAXC][N];
    logic [N*W-1:0] q [$];
    bit ovf_m, skw_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    // one clock cycle: check outputs against the model, drive lanes from the row schedule, advance the model
    task automatic step(input bit start, input logic [N-1:0] mask, input logic [N*W-1:0] dat,
                        input bit ordy, input bit rst);
        int r;
        logic [N*W-1:0] row;
        if (armed) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("out_data", out_data, q.size() != 0 ? q[0] : '0);
            chk("in_ready", in_ready, q.size() <= DEPTH - N);
            chk("overflow", overflow, ovf_m);
            chk("skew_err", skew_err, skw_m);
        end
        if (start) begin
            row_mask[cyc] = mask;
            for (int j = 0; j < N; j++) row_dat[cyc][j] = dat[j*W +: W];
        end
        for (int j = 0; j < N; j++) begin
            r = cyc - j;
            if (r >= 0) begin
                in_valid[j]       = row_mask[r][j];
                in_data[j*W +: W] = row_dat[r][j];
            end else begin
                in_valid[j]       = 1'b0;
                in_data[j*W +: W] = W'($urandom());
            end
        end
        out_ready = ordy;
        clr_n     = !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ovf_m = 0;
            skw_m = 0;
            armed = 1;
            for (int s = cyc - N + 1; s <= cyc; s++) if (s >= 0) row_mask[s] = '0;
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            r = cyc - (N - 1);
            if (r >= 0 && row_mask[r] == '1) begin
                for (int j = 0; j < N; j++) row[j*W +: W] = row_dat[r][j];
                if (q.size() < DEPTH) q.push_back(row);
                else ovf_m = 1;
            end else if (r >= 0 && row_mask[r] != '0) begin
                skw_m = 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit ordy, input int n);
        repeat (n) step(0, '0, '0, ordy, 0);
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            row_mask[i] = '0;
            for (int j = 0; j < N; j++) row_dat[i][j] = '0;
        end
        clr_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        repeat (2) step(0, '0, '0, 0, 1);
        step(1, '1, 64'h1003_1002_1001_1000, 0, 0);
        idle(0, 3);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 64'h1003_1002_1001_1000);
        step(0, '0, '0, 1, 0);
        chk("single_drop", out_valid, 0);
        idle(0, 2);
        for (int i = 0; i < 10; i++) step(1, '1, rnd(), 1, 0);
        idle(1, 8);
        for (int i = 0; i < 20; i++) step(in_ready, '1, rnd(), 0, 0);
        chk("bp_inready", in_ready, 0);
        chk("bp_overflow", overflow, 0);
        idle(1, 16);
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, '1, rnd(), 0, 0);
        idle(0, 4);
        chk("ovf_flag", overflow, 1);
        idle(0, 2);
        chk("ovf_sticky", overflow, 1);
        idle(1, 12);
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, '1, rnd(), 0, 0);
        idle(0, 4);
        step(1, '1, rnd(), 0, 0);
        idle(0, 2);
        step(0, '0, '0, 1, 0);
        chk("fullpp_ovf", overflow, 0);
        idle(0, 1);
        idle(1, 12);
        step(1, 4'b1011, rnd(), 1, 0);
        idle(1, 3);
        chk("skew_flag", skew_err, 1);
        chk("skew_nopush", out_valid, 0);
        step(1, '1, rnd(), 1, 0);
        idle(1, 6);
        for (int i = 0; i < 300; i++) begin
            bit rst, st;
            rst = $urandom_range(99) == 0;
            st  = rst ? 1'b0 : (in_ready ? $urandom_range(3) != 0 : $urandom_range(15) == 0);
            step(st, $urandom_range(9) == 0 ? N'($urandom()) : '1, rnd(), $urandom_range(2) != 0, rst);
        end
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, '1, rnd(), 0, 0);
        idle(0, 4);
        step(1, '1, rnd(), 0, 0);
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 0, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", {overflow, skew_err}, 0);
        idle(1, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
